writeback_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory-access stage.
- Registers the M-stage control and data bundle with stall/flush handling.
- Captures synchronous data-memory read data, which arrives one cycle after the address, and holds it across stalls.
- Extracts and extends load bytes, selects the writeback result, and drives the register-file write port plus the W-stage forwarding value.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/load_extend.sv | 36 +++
 rtl/writeback_stage.sv | 130 +++++++++++++
 tb/tb_writeback_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg : shared pipeline widths and writeback select encodings | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    SRC_ALU    = 3'd0,
    SRC_MEM    = 3'd1,
    SRC_IMM    = 3'd2,
    SRC_PC4    = 3'd3,
    SRC_CSR    = 3'd4,
    SRC_STATUS = 3'd5
  } result_src_e;

  typedef enum logic [1:0] {
    BYTES_WORD  = 2'b00,
    BYTES_BSEXT = 2'b01,
    BYTES_HSEXT = 2'b10,
    BYTES_BZEXT = 2'b11
  } result_bytes_e;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend : combinational load lane extraction and sign/zero extension | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_extend #(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic [XLEN-1:0]              data,
  input  logic [1:0]                   addr,
  input  pipeline_pkg::result_bytes_e  bytes,
  output logic [XLEN-1:0]              ext
);

  import pipeline_pkg::*;

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Shift the addressed lane down to bit 0; misaligned halves are not trapped here.
  assign byte_sh = data >> {addr, 3'b000};
  assign half_sh = data >> {addr[1], 4'b0000};

  always_comb begin
    ext = data;
    case (bytes)
      BYTES_BSEXT: ext = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      BYTES_HSEXT: ext = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      BYTES_BZEXT: ext = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      default:     ext = data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage : W pipeline register, load capture and result select;
// optional RETIRE_COUNT_EN adds a 64-bit instret counter       | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_stage #(
  parameter int XLEN       = pipeline_pkg::XLEN,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall_w,
  input  logic                  flush_w,
  input  logic                  valid_m,
  input  logic                  reg_write_m,
  input  logic [2:0]            result_src_m,
  input  logic [1:0]            result_bytes_m,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [XLEN-1:0]       imm_ext_m,
  input  logic [XLEN-1:0]       pc_plus4_m,
  input  logic [XLEN-1:0]       c_reg_data_m,
  input  logic [XLEN-1:0]       status_m,
  input  logic [XLEN-1:0]       dout,
  output logic                  reg_write_w,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic [XLEN-1:0]       result_w,
  output logic                  valid_w
`ifdef RETIRE_COUNT_EN
  ,output logic [63:0]          instret
`endif
);

  import pipeline_pkg::*;

  logic                  valid_q;
  logic                  reg_write_q;
  logic [2:0]            src_q;
  logic [1:0]            bytes_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       imm_q;
  logic [XLEN-1:0]       pc4_q;
  logic [XLEN-1:0]       csr_q;
  logic [XLEN-1:0]       status_q;
  logic [XLEN-1:0]       load_hold;
  logic                  fresh;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       load_ext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= '0;
      bytes_q     <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      csr_q       <= '0;
      status_q    <= '0;
    end else if (flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall_w) begin
      valid_q     <= valid_m;
      reg_write_q <= reg_write_m;
      src_q       <= result_src_m;
      bytes_q     <= result_bytes_m;
      rd_q        <= rd_m;
      alu_q       <= alu_result_m;
      imm_q       <= imm_ext_m;
      pc4_q       <= pc_plus4_m;
      csr_q       <= c_reg_data_m;
      status_q    <= status_m;
    end
  end

  // Memory data is only live in the first W cycle; snapshot it so stalls see a stable value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_hold <= '0;
      fresh     <= 1'b0;
    end else begin
      if (fresh) load_hold <= dout;
      fresh <= !stall_w && !flush_w;
    end
  end

  assign load_data = fresh ? dout : load_hold;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data  (load_data),
    .addr  (alu_q[1:0]),
    .bytes (result_bytes_e'(bytes_q)),
    .ext   (load_ext)
  );

  always_comb begin
    result_w = '0;
    case (src_q)
      SRC_ALU:    result_w = alu_q;
      SRC_MEM:    result_w = load_ext;
      SRC_IMM:    result_w = imm_q;
      SRC_PC4:    result_w = pc4_q;
      SRC_CSR:    result_w = csr_q;
      SRC_STATUS: result_w = status_q;
      default:    result_w = '0;
    endcase
  end

  assign valid_w     = valid_q;
  assign rd_w        = rd_q;
  assign reg_write_w = valid_q & reg_write_q & (rd_q != '0);

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret <= '0;
    end else if (valid_q && !stall_w && !flush_w) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage : directed self-checking bench for writeback_stage | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_writeback_stage;

  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_w, flush_w, valid_m, reg_write_m;
  logic [2:0]  result_src_m;
  logic [1:0]  result_bytes_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, imm_ext_m, pc_plus4_m, c_reg_data_m, status_m, dout;
  logic        reg_write_w, valid_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
`ifdef RETIRE_COUNT_EN
  logic [63:0] instret;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall_w        (stall_w),
    .flush_w        (flush_w),
    .valid_m        (valid_m),
    .reg_write_m    (reg_write_m),
    .result_src_m   (result_src_m),
    .result_bytes_m (result_bytes_m),
    .rd_m           (rd_m),
    .alu_result_m   (alu_result_m),
    .imm_ext_m      (imm_ext_m),
    .pc_plus4_m     (pc_plus4_m),
    .c_reg_data_m   (c_reg_data_m),
    .status_m       (status_m),
    .dout           (dout),
    .reg_write_w    (reg_write_w),
    .rd_w           (rd_w),
    .result_w       (result_w),
    .valid_w        (valid_w)
`ifdef RETIRE_COUNT_EN
    ,.instret       (instret)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic rw, input logic [2:0] src,
                       input logic [1:0] bytes, input logic [4:0] rd, input logic [31:0] alu);
    valid_m        = v;
    reg_write_m    = rw;
    result_src_m   = src;
    result_bytes_m = bytes;
    rd_m           = rd;
    alu_result_m   = alu;
  endtask

  logic [1:0]  lb [8];
  logic [1:0]  la [8];
  logic [31:0] le [8];
  logic [31:0] se [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lb = '{BYTES_HSEXT, BYTES_BSEXT, BYTES_BZEXT, BYTES_WORD,
           BYTES_BSEXT, BYTES_HSEXT, BYTES_BZEXT, BYTES_WORD};
    la = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
    le = '{32'hFFFF80F1, 32'h0000007F, 32'h00000080, 32'h80F17F01,
           32'h00000001, 32'h00007F01, 32'h000000F1, 32'h80F17F01};
    se = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0};

    rstn = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    imm_ext_m = 32'h11; pc_plus4_m = 32'h22; c_reg_data_m = 32'h33; status_m = 32'h44;
    dout = 32'h0;
    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd5, 32'hCAFE);
    #12;
    check("reset_valid", valid_w, 0);
    check("reset_rw", reg_write_w, 0);
    check("reset_rd", rd_w, 0);
    check("reset_result", result_w, 0);
    @(negedge clk) rstn = 1'b1;

    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd5, 32'h1234);
    step();
    check("alu_valid", valid_w, 1);
    check("alu_rw", reg_write_w, 1);
    check("alu_rd", rd_w, 5);
    check("alu_result", result_w, 32'h1234);

    for (int i = 0; i < 8; i++) begin
      issue(1'b1, 1'b1, SRC_MEM, lb[i], 5'd7, {30'h0, la[i]});
      dout = 32'h0;
      step();
      dout = 32'h80F17F01;
      #1;
      check($sformatf("load_%0d", i), result_w, le[i]);
    end

    issue(1'b1, 1'b1, SRC_MEM, BYTES_WORD, 5'd9, 32'h100);
    step();
    dout = 32'hDEADBEEF;
    #1;
    check("stall_first", result_w, 32'hDEADBEEF);
    stall_w = 1'b1;
    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd3, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      dout = 32'h11111111;
      #1;
      check($sformatf("stall_result_%0d", i), result_w, 32'hDEADBEEF);
      check($sformatf("stall_rd_%0d", i), rd_w, 9);
    end
    stall_w = 1'b0;
    step();
    check("unstall_result", result_w, 32'h55);
    check("unstall_rd", rd_w, 3);

    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd4, 32'h77);
    step();
    check("pre_flush_valid", valid_w, 1);
    flush_w = 1'b1; stall_w = 1'b1;
    step();
    check("flush_stall_valid", valid_w, 0);
    check("flush_stall_rw", reg_write_w, 0);
    flush_w = 1'b0; stall_w = 1'b0;

    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd0, 32'hABC);
    step();
    check("x0_rw", reg_write_w, 0);
    check("x0_valid", valid_w, 1);
    check("x0_result", result_w, 32'hABC);

    issue(1'b1, 1'b0, SRC_ALU, BYTES_WORD, 5'd8, 32'h99);
    step();
    check("nowrite_rw", reg_write_w, 0);

    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b1, 3'(i + 2), BYTES_WORD, 5'd10, 32'h99);
      step();
      check($sformatf("src_%0d", i + 2), result_w, se[i]);
    end

    issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd6, 32'h66);
    step();
    stall_w = 1'b1;
    issue(1'b0, 1'b0, SRC_ALU, BYTES_WORD, 5'd0, 32'h0);
    step();
    check("midstall_rw", reg_write_w, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_rw", reg_write_w, 0);
    check("async_rst_valid", valid_w, 0);
    check("async_rst_result", result_w, 0);
    @(negedge clk) rstn = 1'b1;
    step();
    check("post_rst_stall_valid", valid_w, 0);
    stall_w = 1'b0;

`ifdef RETIRE_COUNT_EN
    @(negedge clk) rstn = 1'b0;
    #1;
    check("instret_reset", instret, 0);
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue(1'b1, 1'b1, SRC_ALU, BYTES_WORD, 5'd1, 32'(i));
      step();
    end
    flush_w = 1'b1;
    issue(1'b0, 1'b0, SRC_ALU, BYTES_WORD, 5'd0, 32'h0);
    step();
    flush_w = 1'b0;
    step();
    step();
    check("instret_count", instret, 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
